// File: rtl/pixel_feeder.sv
// -----------------------------------------------------------------------------
// pixel_feeder
//   Upstream stage of the pixel decoder. Source bytes are buffered in a FIFO and
//   released one line at a time: a single pix_req pulse, then LINE_LEN pixels.
//   A line is only announced once LINE_LEN bytes are already buffered, so a
//   line can never underrun once it has started.
//
// Optional feature macro: PIXEL_FEEDER_PARITY_EN
//   When defined, a parity bit is computed on push, stored as a ninth FIFO bit
//   and presented on pix_parity alongside pixel_in.
//
// Ports
//   clk         in   rising-edge system clock
//   rst         in   synchronous active-high reset (aborts frame, flushes FIFO)
//   en          in   stream enable; low only stalls popping in STREAM
//   start       in   1-cycle frame start, ignored while busy
//   num_lines   in   lines per frame, sampled on start (0 means 256)
//   src_valid   in   source byte valid
//   src_data    in   source byte
//   src_ready   out  FIFO not full
//   pix_req     out  1-cycle pulse announcing a line
//   pixel_in    out  registered pixel to the decoder
//   pix_valid   out  pixel_in valid this cycle
//   fifo_count  out  FIFO occupancy
//   busy        out  FSM not idle
//   frame_done  out  1-cycle pulse the cycle after the frame's last pixel
//   pix_parity  out  (PIXEL_FEEDER_PARITY_EN only) ^pixel_in
// -----------------------------------------------------------------------------
module pixel_feeder #(
  parameter int DEPTH    = 64,
  parameter int AW       = 6,
  parameter int LINE_LEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic [7:0]    num_lines,
  input  logic          src_valid,
  input  logic [7:0]    src_data,
  output logic          src_ready,
  output logic          pix_req,
  output logic [7:0]    pixel_in,
  output logic          pix_valid,
  output logic [AW:0]   fifo_count,
  output logic          busy,
  output logic          frame_done
`ifdef PIXEL_FEEDER_PARITY_EN
  ,
  output logic          pix_parity
`endif
);

`ifdef PIXEL_FEEDER_PARITY_EN
  localparam int FW = 9;
`else
  localparam int FW = 8;
`endif

  localparam logic [AW:0] DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [AW:0] LINE_LEN_C = (AW+1)'(LINE_LEN);
  localparam logic [AW:0] LAST_PIX_C = (AW+1)'(LINE_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_REQ    = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  function automatic logic calc_parity(input logic [7:0] data);
    return ^data;
  endfunction

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [8:0]      lines_left_q, lines_left_d;
  logic [AW:0]     pix_cnt_q, pix_cnt_d;
  logic [7:0]      pixel_q, pixel_d;
  logic            pix_valid_q, pix_valid_d;
  logic            pix_req_q, pix_req_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            done_pend_q, done_pend_d;
  logic            frame_done_q, frame_done_d;
  logic            parity_q, parity_d;

  logic [FW-1:0]   mem_q [DEPTH];
  logic [FW-1:0]   wdata_s;
  logic [FW-1:0]   head_s;
  logic            push_s;
  logic            pop_s;

`ifdef PIXEL_FEEDER_PARITY_EN
  assign wdata_s = {calc_parity(src_data), src_data};
`else
  assign wdata_s = src_data;
`endif
  assign head_s = mem_q[rd_ptr_q];

  // Next-state, FIFO bookkeeping and output computation
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    lines_left_d = lines_left_q;
    pix_cnt_d    = pix_cnt_q;
    pixel_d      = pixel_q;
    parity_d     = parity_q;
    pix_valid_d  = 1'b0;
    pix_req_d    = 1'b0;
    done_pend_d  = 1'b0;
    // frame_done trails the last pix_valid by one cycle
    frame_done_d = done_pend_q;
    pop_s        = 1'b0;
    // ready_q mirrors !full of the current count, so a same-cycle pop never
    // re-opens a full FIFO
    push_s       = src_valid & ready_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_FILL;
          lines_left_d = (num_lines == 8'd0) ? 9'd256 : {1'b0, num_lines};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (count_q >= LINE_LEN_C) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_REQ: begin
        // pix_req registers here so it is high in the first STREAM cycle,
        // one cycle ahead of the first pix_valid
        state_d   = ST_STREAM;
        pix_cnt_d = '0;
        pix_req_d = 1'b1;
      end
      ST_STREAM: begin
        if (en) begin
          pop_s       = 1'b1;
          pixel_d     = head_s[7:0];
          pix_valid_d = 1'b1;
`ifdef PIXEL_FEEDER_PARITY_EN
          parity_d    = head_s[8];
`endif
          pix_cnt_d   = pix_cnt_q + (AW+1)'(1);
          if (pix_cnt_q == LAST_PIX_C) begin
            lines_left_d = lines_left_q - 9'd1;
            if (lines_left_q == 9'd1) begin
              state_d     = ST_IDLE;
              done_pend_d = 1'b1;
            end else begin
              state_d = ST_FILL;
            end
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    ready_d = (count_d != DEPTH_C);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      lines_left_q <= 9'd0;
      pix_cnt_q    <= '0;
      pixel_q      <= 8'h00;
      pix_valid_q  <= 1'b0;
      pix_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
      done_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      parity_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      lines_left_q <= lines_left_d;
      pix_cnt_q    <= pix_cnt_d;
      pixel_q      <= pixel_d;
      pix_valid_q  <= pix_valid_d;
      pix_req_q    <= pix_req_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      done_pend_q  <= done_pend_d;
      frame_done_q <= frame_done_d;
      parity_q     <= parity_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_s;
    end
  end

  assign src_ready  = ready_q;
  assign pix_req    = pix_req_q;
  assign pixel_in   = pixel_q;
  assign pix_valid  = pix_valid_q;
  assign fifo_count = count_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
`ifdef PIXEL_FEEDER_PARITY_EN
  assign pix_parity = parity_q;
`endif

endmodule

// File: tb/tb_pixel_feeder.sv
module tb_pixel_feeder;

  logic       clk = 1'b0;
  logic       rst, en, start, src_valid;
  logic [7:0] num_lines, src_data;
  logic       src_ready, pix_req, pix_valid, busy, frame_done;
  logic [7:0] pixel_in;
  logic [6:0] fifo_count;
`ifdef PIXEL_FEEDER_PARITY_EN
  logic       pix_parity;
`endif

  always #5 clk = ~clk;

  pixel_feeder dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .num_lines(num_lines),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .pix_req(pix_req), .pixel_in(pixel_in), .pix_valid(pix_valid),
    .fifo_count(fifo_count), .busy(busy), .frame_done(frame_done)
`ifdef PIXEL_FEEDER_PARITY_EN
    , .pix_parity(pix_parity)
`endif
  );

  // Reference model: bytes accepted but not yet delivered, in arrival order
  logic [7:0] mq[$];
  int total = 0, bad = 0;
  int cyc = 0, last_valid_cyc = -10;
  int beats, reqs, dones, pix_errs, stall_err, lat_err, fd_err;
  int cnt_err, rdy_err, req_early, par_err;
  bit req_prev = 1'b0;

  task automatic clear_obs();
    beats = 0; reqs = 0; dones = 0; pix_errs = 0; stall_err = 0; lat_err = 0;
    fd_err = 0; cnt_err = 0; rdy_err = 0; req_early = 0; par_err = 0;
  endtask

  // One clock: capture inputs at the edge, observe outputs at the falling edge
  task automatic tick();
    logic acc, en_e, rst_e;
    logic [7:0] d_e, exp_b;
    @(posedge clk);
    rst_e = rst; en_e = en; d_e = src_data;
    acc = src_valid && (mq.size() < 64);
    @(negedge clk);
    cyc++;
    if (rst_e) begin
      mq.delete();
      if (pix_valid !== 1'b0) pix_errs++;
      req_prev = 1'b0;
    end else begin
      if (pix_valid === 1'b1) begin
        beats++;
        last_valid_cyc = cyc;
        if (!en_e) stall_err++;
        if (mq.size() == 0) pix_errs++;
        else begin
          exp_b = mq.pop_front();
          if (pixel_in !== exp_b) pix_errs++;
`ifdef PIXEL_FEEDER_PARITY_EN
          if (pix_parity !== ^exp_b) par_err++;
`endif
        end
      end
      if (acc) mq.push_back(d_e);
      if (req_prev && en_e && pix_valid !== 1'b1) lat_err++;
      if (pix_req === 1'b1) begin
        reqs++;
        if (mq.size() < 32) req_early++;
      end
      if (frame_done === 1'b1) begin
        dones++;
        if (cyc != last_valid_cyc + 1) fd_err++;
      end
      req_prev = (pix_req === 1'b1);
    end
    if (int'(fifo_count) != mq.size()) cnt_err++;
    if (src_ready !== (mq.size() != 64)) rdy_err++;
  endtask

  task automatic pulse_start(input logic [7:0] nl);
    num_lines = nl; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && dones == 0; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++; if (src_ready !== 1'b1) begin bad++; $display("FAIL reset_src_ready got=%b want=1", src_ready); end
    total++; if (fifo_count !== 7'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (pix_req !== 1'b0) begin bad++; $display("FAIL reset_pix_req got=%b want=0", pix_req); end
    total++; if (pixel_in !== 8'h00) begin bad++; $display("FAIL reset_pixel got=%h want=00", pixel_in); end
    total++; if (pix_valid !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL reset_valid_done got=%b%b want=00", pix_valid, frame_done); end
  endtask

  task automatic test_single_line();
    clear_obs();
    src_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin src_data = 8'(i); tick(); end
    src_valid = 1'b0;
    pulse_start(8'd1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
    wait_done(200);
    tick(); tick();
    total++; if (reqs != 1) begin bad++; $display("FAIL single_reqs got=%0d want=1", reqs); end
    total++; if (beats != 32) begin bad++; $display("FAIL single_beats got=%0d want=32", beats); end
    total++; if (dones != 1) begin bad++; $display("FAIL single_done got=%0d want=1", dones); end
    total++; if (pix_errs + lat_err + fd_err != 0) begin bad++; $display("FAIL single_order_timing got=%0d/%0d/%0d want=0/0/0", pix_errs, lat_err, fd_err); end
    total++; if (fifo_count !== 7'd0 || busy !== 1'b0) begin bad++; $display("FAIL single_end got=%0d,%b want=0,0", fifo_count, busy); end
    total++; if (cnt_err + rdy_err != 0) begin bad++; $display("FAIL single_fifo_track got=%0d/%0d want=0/0", cnt_err, rdy_err); end
  endtask

  task automatic test_full();
    clear_obs();
    src_valid = 1'b1;
    for (int i = 0; i < 70; i++) begin src_data = 8'(i); tick(); end
    src_valid = 1'b0;
    total++; if (fifo_count !== 7'd64) begin bad++; $display("FAIL full_count got=%0d want=64", fifo_count); end
    total++; if (src_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", src_ready); end
    total++; if (cnt_err + rdy_err != 0) begin bad++; $display("FAIL full_track got=%0d/%0d want=0/0", cnt_err, rdy_err); end
  endtask

  task automatic test_stall();
    int zeros = 0;
    clear_obs();
    pulse_start(8'd2);
    for (int i = 0; i < 300 && beats < 10; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); if (pix_valid === 1'b0) zeros++; end
    en = 1'b1;
    tick();
    total++; if (zeros != 3) begin bad++; $display("FAIL stall_gap got=%0d want=3", zeros); end
    total++; if (pix_valid !== 1'b1 || pixel_in !== 8'h0A) begin bad++; $display("FAIL stall_resume got=%b,%h want=1,0a", pix_valid, pixel_in); end
    wait_done(300);
    total++; if (beats != 64 || dones != 1) begin bad++; $display("FAIL stall_frame got=%0d,%0d want=64,1", beats, dones); end
    total++; if (pix_errs + stall_err != 0) begin bad++; $display("FAIL stall_order got=%0d/%0d want=0/0", pix_errs, stall_err); end
    total++; if (fifo_count !== 7'd0) begin bad++; $display("FAIL stall_drain got=%0d want=0", fifo_count); end
  endtask

  task automatic test_multi_line();
    clear_obs();
    pulse_start(8'd2);
    src_valid = 1'b1;
    for (int i = 0; i < 52; i++) begin src_data = 8'($urandom); tick(); end
    src_valid = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    total++; if (reqs != 1 || beats != 32) begin bad++; $display("FAIL starve_line1 got=%0d,%0d want=1,32", reqs, beats); end
    total++; if (fifo_count !== 7'd20 || busy !== 1'b1 || dones != 0) begin bad++; $display("FAIL starve_wait got=%0d,%b,%0d want=20,1,0", fifo_count, busy, dones); end
    src_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin src_data = 8'($urandom); tick(); end
    src_valid = 1'b0;
    wait_done(200);
    total++; if (reqs != 2 || beats != 64 || dones != 1) begin bad++; $display("FAIL starve_line2 got=%0d,%0d,%0d want=2,64,1", reqs, beats, dones); end
    total++; if (req_early + pix_errs + lat_err + fd_err != 0) begin bad++; $display("FAIL starve_rules got=%0d/%0d/%0d/%0d want=0", req_early, pix_errs, lat_err, fd_err); end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      int nl = $urandom_range(1, 3);
      clear_obs();
      pulse_start(8'(nl));
      for (int i = 0; i < 4000 && dones == 0; i++) begin
        src_valid = ($urandom_range(0, 3) != 0);
        src_data  = 8'($urandom);
        en        = ($urandom_range(0, 4) != 0);
        start     = busy && ($urandom_range(0, 9) == 0);
        num_lines = 8'($urandom_range(1, 5));
        tick();
      end
      src_valid = 1'b0; en = 1'b1; start = 1'b0;
      tick(); tick();
      total++; if (beats != nl * 32 || reqs != nl || dones != 1) begin bad++; $display("FAIL rand_frame%0d got=%0d,%0d,%0d want=%0d,%0d,1", f, beats, reqs, dones, nl * 32, nl); end
      total++; if (pix_errs + stall_err + lat_err + fd_err + req_early + cnt_err + rdy_err + par_err != 0) begin bad++;
        $display("FAIL rand_rules%0d pix=%0d stall=%0d lat=%0d fd=%0d early=%0d cnt=%0d rdy=%0d par=%0d want=all 0", f, pix_errs, stall_err, lat_err, fd_err, req_early, cnt_err, rdy_err, par_err); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_idle%0d got=%b want=0", f, busy); end
    end
  endtask

  task automatic test_zero_lines();
    clear_obs();
    pulse_start(8'd0);
    src_valid = 1'b1;
    for (int i = 0; i < 20000 && dones == 0; i++) begin src_data = 8'($urandom); tick(); end
    src_valid = 1'b0;
    total++; if (reqs != 256 || beats != 8192 || dones != 1) begin bad++; $display("FAIL zero_lines got=%0d,%0d,%0d want=256,8192,1", reqs, beats, dones); end
    total++; if (pix_errs + req_early + cnt_err != 0) begin bad++; $display("FAIL zero_rules got=%0d/%0d/%0d want=0", pix_errs, req_early, cnt_err); end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    src_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin src_data = 8'($urandom); tick(); end
    src_valid = 1'b0;
    pulse_start(8'd1);
    for (int i = 0; i < 300 && beats < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0 || fifo_count !== 7'd0 || pix_valid !== 1'b0) begin bad++; $display("FAIL rstmid_state got=%b,%0d,%b want=0,0,0", busy, fifo_count, pix_valid); end
    for (int i = 0; i < 50; i++) tick();
    total++; if (dones != 0 || beats != 5) begin bad++; $display("FAIL rstmid_quiet got=%0d,%0d want=0,5", dones, beats); end
    total++; if (src_ready !== 1'b1 || pix_errs + par_err != 0) begin bad++; $display("FAIL rstmid_after got=%b,%0d,%0d want=1,0,0", src_ready, pix_errs, par_err); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; num_lines = 8'd0;
    src_valid = 1'b0; src_data = 8'd0;
    clear_obs();
    test_reset();
    test_single_line();
    test_full();
    test_stall();
    test_multi_line();
    test_random_frames();
    test_zero_lines();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
